// File: rtl/ws2812_rx.sv
// WS2812 single-wire receiver: decodes the first 24 bits after a latch into G/R/B bytes.
// Define WS2812_RX_FORWARD_EN to re-drive bits 25 onward on o_dout; otherwise o_dout is tied low.
module ws2812_rx #(
  parameter int CLK_FREQ  = 16000000,
  parameter int T_THRESH  = int'((64'(CLK_FREQ) * 64'd6) / 64'd10000000),
  parameter int T_GLITCH  = 2,
  parameter int LATCH_MIN = CLK_FREQ / 20000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ws2812,
  output logic [7:0] o_green,
  output logic [7:0] o_red,
  output logic [7:0] o_blue,
  output logic       o_valid,
  output logic       o_dout,
  output logic       o_busy,
  output logic       o_err
);

  localparam int CW = $clog2(LATCH_MIN + 1);
  localparam logic [CW-1:0] THRESH_C = CW'(T_THRESH);
  localparam logic [CW-1:0] GLITCH_C = CW'(T_GLITCH);
  localparam logic [CW-1:0] LATCH_C  = CW'(LATCH_MIN);
  localparam logic [CW-1:0] HI_MAX   = '1;

  typedef enum logic [1:0] {SYNC, IDLE, CAPTURE, FORWARD} state_e;

  logic          sync1_q, sync2_q, line_q;
  logic          rise, fall, latch, stuck;
  state_e        state_q, state_d;
  logic [CW-1:0] hi_cnt_q, hi_cnt_d;
  logic [CW-1:0] lo_cnt_q, lo_cnt_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic          load_q, load_d;
  logic [7:0]    green_q, green_d, red_q, red_d, blue_q, blue_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    rise  = sync2_q & ~line_q;
    fall  = ~sync2_q & line_q;
    latch = (lo_cnt_q == LATCH_C);
    stuck = sync2_q && (hi_cnt_q == HI_MAX);

    // The rising-edge cycle is the first high cycle, so a fall sees hi_cnt equal to the high time.
    hi_cnt_d = hi_cnt_q;
    if (rise)
      hi_cnt_d = CW'(1);
    else if (sync2_q && (hi_cnt_q != HI_MAX))
      hi_cnt_d = hi_cnt_q + 1'b1;

    lo_cnt_d = lo_cnt_q;
    if (rise)
      lo_cnt_d = '0;
    else if (!sync2_q && (lo_cnt_q != LATCH_C))
      lo_cnt_d = lo_cnt_q + 1'b1;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    load_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      SYNC: begin
        if (latch) state_d = IDLE;
      end
      IDLE: begin
      end
      CAPTURE: begin
        if (latch) begin
          err_d     = (bit_cnt_q != 5'd0);
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
        end else if (stuck) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          bit_cnt_d = 5'd0;
        end else if (fall) begin
          if (hi_cnt_q < GLITCH_C) begin
            err_d     = 1'b1;
            state_d   = SYNC;
            bit_cnt_d = 5'd0;
          end else begin
            shift_d   = {shift_q[22:0], (hi_cnt_q >= THRESH_C)};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
              load_d  = 1'b1;
              state_d = FORWARD;
            end
          end
        end
      end
      FORWARD: begin
        if (latch) begin
          state_d   = IDLE;
          bit_cnt_d = 5'd0;
        end else if (stuck || (fall && (hi_cnt_q < GLITCH_C))) begin
          err_d     = 1'b1;
          state_d   = SYNC;
          bit_cnt_d = 5'd0;
        end
      end
      default: state_d = SYNC;
    endcase

    // A latch resolved above lands in IDLE first, so a coincident rise still opens a new frame.
    if ((state_d == IDLE) && rise) begin
      state_d   = CAPTURE;
      bit_cnt_d = 5'd0;
    end

    green_d = load_q ? shift_q[23:16] : green_q;
    red_d   = load_q ? shift_q[15:8]  : red_q;
    blue_d  = load_q ? shift_q[7:0]   : blue_q;
    valid_d = load_q;
    busy_d  = (state_d == CAPTURE) || (state_d == FORWARD);
  end

`ifdef WS2812_RX_FORWARD_EN
  logic dout_q, dout_d;
  always_comb dout_d = (state_d == FORWARD) & sync2_q;
  assign o_dout = dout_q;
`else
  assign o_dout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      line_q    <= 1'b0;
      state_q   <= SYNC;
      hi_cnt_q  <= '0;
      lo_cnt_q  <= '0;
      bit_cnt_q <= 5'd0;
      shift_q   <= 24'd0;
      load_q    <= 1'b0;
      green_q   <= 8'd0;
      red_q     <= 8'd0;
      blue_q    <= 8'd0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
`ifdef WS2812_RX_FORWARD_EN
      dout_q    <= 1'b0;
`endif
    end else begin
      sync1_q   <= i_ws2812;
      sync2_q   <= sync1_q;
      line_q    <= sync2_q;
      state_q   <= state_d;
      hi_cnt_q  <= hi_cnt_d;
      lo_cnt_q  <= lo_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      load_q    <= load_d;
      green_q   <= green_d;
      red_q     <= red_d;
      blue_q    <= blue_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
`ifdef WS2812_RX_FORWARD_EN
      dout_q    <= dout_d;
`endif
    end
  end

  assign o_green = green_q;
  assign o_red   = red_q;
  assign o_blue  = blue_q;
  assign o_valid = valid_q;
  assign o_busy  = busy_q;
  assign o_err   = err_q;

endmodule
